tiled_scanout_reader: RTL and testbench

- Reads a framebuffer stored in the Morton-swizzled tiled layout and emits pixels as a raster-order stream for display scanout or CPU readback.
- Acts as the reader for what the ROP/DMA tile-address writer produces.
- Generates one memory read request per pixel and accepts in-order responses.
- Buffers responses in a credit-limited FIFO and presents pixels on a valid/ready stream with line and frame markers.

---
 rtl/tiled_scanout_reader_if.sv | 35 +++
 rtl/tiled_scanout_reader.sv | 207 ++++++++++++++++++++
 tb/tb_tiled_scanout_reader.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tiled_scanout_reader_if.sv
// tiled_scanout_reader_if: memory read request/response channel and pixel output stream.
interface tiled_scanout_reader_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned PW     = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [PW-1:0]     rsp_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [PW-1:0]     pix_data;
    logic              pix_sol;
    logic              pix_eol;
    logic              pix_eof;

    // Reader side: issues requests, consumes responses, sources pixels.
    modport master (
        output req_valid, req_addr,
        input  req_ready,
        input  rsp_valid, rsp_data,
        output pix_valid, pix_data, pix_sol, pix_eol, pix_eof,
        input  pix_ready
    );

    // Memory and display side.
    modport slave (
        input  req_valid, req_addr,
        output req_ready,
        output rsp_valid, rsp_data,
        input  pix_valid, pix_data, pix_sol, pix_eol, pix_eof,
        output pix_ready
    );
endinterface

// File: rtl/tiled_scanout_reader.sv
// tiled_scanout_reader: walks a Morton-tiled framebuffer in raster order, one read
// per pixel, buffers in-order responses in a credit-limited FIFO and streams pixels
// with line/frame markers. Optional `SCANOUT_LINEAR_MODE_EN adds a linear layout.
module tiled_scanout_reader #(
    parameter int unsigned TILE_LOG2      = 3,
    parameter int unsigned DIM_LOG2       = 12,
    parameter int unsigned PIX_BYTES_LOG2 = 2,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [ADDR_W-1:0]               base_addr,
    input  logic [DIM_LOG2-TILE_LOG2:0]     width_tiles,
    input  logic [DIM_LOG2-TILE_LOG2:0]     height_tiles,
`ifdef SCANOUT_LINEAR_MODE_EN
    input  logic                            linear_mode,
`endif
    output logic                            busy,
    output logic                            done,
    tiled_scanout_reader_if.master          bus
);
    localparam int unsigned PW     = 8 << PIX_BYTES_LOG2;
    localparam int unsigned TW     = DIM_LOG2 - TILE_LOG2;
    localparam int unsigned OFF_W  = 2 * DIM_LOG2;
    localparam int unsigned BOFF_W = OFF_W + PIX_BYTES_LOG2;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base_q;
    logic [DIM_LOG2-1:0] w_last, h_last;
    logic [DIM_LOG2-1:0] x, y, ox, oy;
    logic [CNT_W-1:0]    outstanding, fifo_count;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]       mem [FIFO_DEPTH];

    logic [DIM_LOG2:0]   w_pix, h_pix;
    logic [CNT_W:0]      in_flight;
    logic                zero_dim, req_hs, pix_hs, fifo_nempty;
    logic                x_last, last_req, last_pix;
    logic [TW-1:0]       tx, ty;
    logic [2*TW-1:0]     morton;
    logic [OFF_W-1:0]    tile_off, pix_off;

    assign w_pix       = {width_tiles, {TILE_LOG2{1'b0}}};
    assign h_pix       = {height_tiles, {TILE_LOG2{1'b0}}};
    assign zero_dim    = (width_tiles == '0) || (height_tiles == '0);
    assign req_hs      = bus.req_valid && bus.req_ready;
    assign fifo_nempty = (fifo_count != '0);
    assign pix_hs      = fifo_nempty && bus.pix_ready;
    assign x_last      = (x == w_last);
    assign last_req    = x_last && (y == h_last);
    assign last_pix    = (ox == w_last) && (oy == h_last);

    // Credit: never have more reads in flight than free FIFO slots.
    assign in_flight     = {1'b0, outstanding} + {1'b0, fifo_count};
    assign bus.req_valid = (state == S_ISSUE) && (in_flight < (CNT_W+1)'(FIFO_DEPTH));

    // Morton tile index: tx on even bits, ty on odd bits.
    assign tx = x[DIM_LOG2-1:TILE_LOG2];
    assign ty = y[DIM_LOG2-1:TILE_LOG2];
    always_comb begin
        morton = '0;
        for (int unsigned i = 0; i < TW; i++) begin
            morton[2*i]   = tx[i];
            morton[2*i+1] = ty[i];
        end
    end
    assign tile_off = {morton, y[TILE_LOG2-1:0], x[TILE_LOG2-1:0]};

`ifdef SCANOUT_LINEAR_MODE_EN
    logic             linear_q;
    logic [OFF_W-1:0] row_base;

    // Running y*W so the linear layout needs no per-pixel multiply.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            linear_q <= 1'b0;
            row_base <= '0;
        end else if ((state == S_IDLE) && start) begin
            linear_q <= linear_mode;
            row_base <= '0;
        end else if ((state == S_ISSUE) && req_hs && x_last) begin
            row_base <= row_base + OFF_W'(w_last) + OFF_W'(1);
        end
    end

    assign pix_off = linear_q ? (row_base + OFF_W'(x)) : tile_off;
`else
    assign pix_off = tile_off;
`endif

    assign bus.req_addr = base_q + ADDR_W'(BOFF_W'(pix_off) << PIX_BYTES_LOG2);

    // Pixel stream: FIFO head plus markers, forced to zero when empty.
    assign bus.pix_valid = fifo_nempty;
    assign bus.pix_data  = fifo_nempty ? mem[rd_ptr] : '0;
    assign bus.pix_sol   = fifo_nempty && (ox == '0);
    assign bus.pix_eol   = fifo_nempty && (ox == w_last);
    assign bus.pix_eof   = fifo_nempty && last_pix;

    // Response storage; contents need no reset since the output is gated by occupancy.
    always_ff @(posedge clk) begin
        if (bus.rsp_valid) mem[wr_ptr] <= bus.rsp_data;
    end

    // FIFO pointers, occupancy and outstanding-read count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
        end else begin
            if (bus.rsp_valid) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pix_hs)        rd_ptr <= rd_ptr + PTR_W'(1);
            case ({bus.rsp_valid, pix_hs})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: ;
            endcase
            case ({req_hs, bus.rsp_valid})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Output position counter driving the markers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ox <= '0;
            oy <= '0;
        end else if (pix_hs) begin
            if (ox == w_last) begin
                ox <= '0;
                oy <= (oy == h_last) ? '0 : oy + DIM_LOG2'(1);
            end else begin
                ox <= ox + DIM_LOG2'(1);
            end
        end
    end

    // Frame control FSM with request walk and registered busy/done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            base_q <= '0;
            w_last <= '0;
            h_last <= '0;
            x      <= '0;
            y      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        w_last <= DIM_LOG2'(w_pix - (DIM_LOG2+1)'(1));
                        h_last <= DIM_LOG2'(h_pix - (DIM_LOG2+1)'(1));
                        x      <= '0;
                        y      <= '0;
                        if (zero_dim) begin
                            state <= S_FIN;
                        end else begin
                            state <= S_ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (req_hs) begin
                        if (x_last) begin
                            x <= '0;
                            if (last_req) begin
                                y     <= '0;
                                state <= S_DRAIN;
                            end else begin
                                y <= y + DIM_LOG2'(1);
                            end
                        end else begin
                            x <= x + DIM_LOG2'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (pix_hs && last_pix) begin
                        state <= S_FIN;
                        busy  <= 1'b0;
                    end
                end
                S_FIN: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tiled_scanout_reader.sv
// tb_tiled_scanout_reader: randomized bench with a memory model returning data=address
// and an arithmetic reference of the tiled/linear address map and raster markers.
module tb_tiled_scanout_reader;
    localparam int unsigned TILE_LOG2      = 3;
    localparam int unsigned DIM_LOG2       = 12;
    localparam int unsigned PIX_BYTES_LOG2 = 2;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned FIFO_DEPTH     = 8;
    localparam int unsigned PW             = 32;
    localparam int unsigned WT_W           = DIM_LOG2 - TILE_LOG2 + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [WT_W-1:0]   width_tiles = '0;
    logic [WT_W-1:0]   height_tiles = '0;
`ifdef SCANOUT_LINEAR_MODE_EN
    logic              linear_mode = 1'b0;
`endif
    logic              busy, done;

    tiled_scanout_reader_if #(.ADDR_W(ADDR_W), .PW(PW)) bus ();

    tiled_scanout_reader #(
        .TILE_LOG2(TILE_LOG2), .DIM_LOG2(DIM_LOG2), .PIX_BYTES_LOG2(PIX_BYTES_LOG2),
        .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_addr(base_addr),
        .width_tiles(width_tiles),
        .height_tiles(height_tiles),
`ifdef SCANOUT_LINEAR_MODE_EN
        .linear_mode(linear_mode),
`endif
        .busy(busy),
        .done(done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } rsp_t;
    typedef struct { logic [31:0] data; bit sol; bit eol; bit eof; } pix_t;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_due = 0;
    int   hs_cnt, pix_cnt, done_cnt;
    bit   rnd_mode = 0, pix_hold = 0, noise = 0;
    bit   saw_busy, saw_req;
    bit   prev_req_stall = 0, prev_pix_stall = 0;
    logic [31:0] prev_req_addr;
    pix_t hold_pix;
    rsp_t mq[$];
    pix_t exp_q[$];
    pix_t exp_all[$];
    logic [31:0] req_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference address map straight from the layout definition.
    function automatic logic [31:0] model_addr(input logic [31:0] base, input int w,
                                               input int x, input int y, input bit lin);
        longint off, m;
        int t, tx, ty;
        t = 1 << TILE_LOG2;
        if (lin) begin
            off = longint'(y) * w + x;
        end else begin
            tx = x / t;
            ty = y / t;
            m  = 0;
            for (int i = 0; i < 16; i++) begin
                m += longint'((tx >> i) & 1) << (2 * i);
                m += longint'((ty >> i) & 1) << (2 * i + 1);
            end
            off = m * t * t + longint'(y % t) * t + (x % t);
        end
        return base + 32'(off << PIX_BYTES_LOG2);
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_req_valid"}, bus.req_valid, 0);
        check({tag, "_req_addr"}, bus.req_addr, 0);
        check({tag, "_pix_valid"}, bus.pix_valid, 0);
        check({tag, "_pix_data"}, bus.pix_data, 0);
        check({tag, "_markers"}, {bus.pix_sol, bus.pix_eol, bus.pix_eof}, 0);
    endtask

    // One clock: drive inputs on the falling edge and observe the coming rising edge.
    task automatic tick();
        int   lat, due;
        pix_t e;
        @(negedge clk);
        cyc++;
        if (noise && busy) begin
            start        = 1'b1;
            base_addr    = $urandom;
            width_tiles  = WT_W'($urandom_range(0, 3));
            height_tiles = WT_W'($urandom_range(0, 3));
        end else begin
            start = 1'b0;
        end
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_data  = mq[0].addr;
            void'(mq.pop_front());
        end else begin
            bus.rsp_valid = 1'b0;
            bus.rsp_data  = $urandom;
        end
        bus.req_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.pix_ready = pix_hold ? 1'b0 : (rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1);

        if (prev_req_stall) begin
            check("req_valid_stable", bus.req_valid, 1);
            check("req_addr_stable", bus.req_addr, prev_req_addr);
        end
        if (bus.req_valid && bus.req_ready) begin
            hs_cnt++;
            req_log.push_back(bus.req_addr);
            lat = rnd_mode ? int'($urandom_range(1, 6)) : 1;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: bus.req_addr, due: due});
        end
        prev_req_stall = bus.req_valid && !bus.req_ready;
        prev_req_addr  = bus.req_addr;

        if (prev_pix_stall) begin
            check("pix_valid_stable", bus.pix_valid, 1);
            check("pix_data_stable", bus.pix_data, hold_pix.data);
            check("pix_markers_stable", {bus.pix_sol, bus.pix_eol, bus.pix_eof},
                  {hold_pix.sol, hold_pix.eol, hold_pix.eof});
        end
        if (bus.pix_valid && bus.pix_ready) begin
            pix_cnt++;
            if (exp_q.size() == 0) begin
                check("pix_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pix_data", bus.pix_data, e.data);
                check("pix_markers", {bus.pix_sol, bus.pix_eol, bus.pix_eof}, {e.sol, e.eol, e.eof});
            end
        end
        prev_pix_stall = bus.pix_valid && !bus.pix_ready;
        hold_pix = '{data: bus.pix_data, sol: bus.pix_sol, eol: bus.pix_eol, eof: bus.pix_eof};
        if (done) done_cnt++;
        saw_busy |= busy;
        saw_req  |= bus.req_valid;
    endtask

    task automatic run_frame(input logic [31:0] base, input int wt, input int ht, input bit lin,
                             input bit rnd, input bit nz, input int hold, input int abort_at);
        int w, h, n_bad;
        bit finished;
        w = wt << TILE_LOG2;
        h = ht << TILE_LOG2;
        exp_all.delete();
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                exp_all.push_back('{data: model_addr(base, w, xx, yy, lin), sol: (xx == 0),
                                    eol: (xx == w - 1), eof: (xx == w - 1 && yy == h - 1)});
        exp_q = exp_all;
        hs_cnt = 0; pix_cnt = 0; done_cnt = 0;
        req_log.delete();
        rnd_mode = rnd; noise = 0; pix_hold = (hold > 0);
        tick();
        start        = 1'b1;
        base_addr    = base;
        width_tiles  = WT_W'(wt);
        height_tiles = WT_W'(ht);
`ifdef SCANOUT_LINEAR_MODE_EN
        linear_mode  = lin;
`endif
        noise    = nz;
        finished = 0;
        for (int n = 1; n <= 20000 && !finished; n++) begin
            tick();
            if (hold > 0 && n == hold) begin
                check("hold_req_count", hs_cnt, FIFO_DEPTH);
                check("hold_req_valid", bus.req_valid, 0);
                check("hold_no_pixels", pix_cnt, 0);
                pix_hold = 0;
            end
            if (abort_at > 0 && n == abort_at) begin
                noise = 0;
                return;
            end
            if (done_cnt != 0) finished = 1;
        end
        noise = 0;
        check("frame_done_seen", finished, 1);
        repeat (3) tick();
        check("done_pulses", done_cnt, 1);
        check("pix_count", pix_cnt, w * h);
        check("req_count", hs_cnt, w * h);
        check("pix_leftover", exp_q.size(), 0);
        n_bad = 0;
        for (int i = 0; i < req_log.size() && i < exp_all.size(); i++)
            if (req_log[i] !== exp_all[i].data) n_bad++;
        check("req_addr_order_errors", n_bad, 0);
    endtask

    initial begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        bus.pix_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        // Directed frame: stall-free, unit latency, with absolute address spot checks.
        run_frame(32'h1000, 2, 2, 0, 0, 0, 0, 0);
        check("addr_0_0", req_log[0], 32'h1000);
        check("addr_1_0", req_log[1], 32'h1004);
        check("addr_0_1", req_log[16], 32'h1020);
        check("addr_8_0", req_log[8], 32'h1100);
        check("addr_0_8", req_log[128], 32'h1200);
        check("addr_8_8", req_log[136], 32'h1300);

        // Downstream held off: credits run out after exactly FIFO_DEPTH requests.
        run_frame(32'h1000, 2, 2, 0, 0, 0, 40, 0);

        // Random request stalls, response latency and pixel backpressure, plus ignored starts.
        run_frame(32'h1000, 2, 2, 0, 1, 1, 0, 0);
        for (int k = 0; k < 4; k++)
            run_frame($urandom, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 0, 1, 1, 0, 0);

        // Zero-dimension frames: done only, two cycles after start.
        for (int k = 0; k < 2; k++) begin
            rnd_mode = 0; noise = 0;
            tick();
            saw_busy = 0; saw_req = 0; done_cnt = 0;
            start        = 1'b1;
            base_addr    = 32'h4000;
            width_tiles  = (k == 0) ? WT_W'(0) : WT_W'(2);
            height_tiles = (k == 0) ? WT_W'(2) : WT_W'(0);
            tick();
            check("zd_done_early", done, 0);
            tick();
            check("zd_done_pulse", done, 1);
            tick();
            check("zd_done_width", done, 0);
            repeat (2) tick();
            check("zd_busy_never", saw_busy, 0);
            check("zd_req_never", saw_req, 0);
            check("zd_done_count", done_cnt, 1);
        end

        // Reset mid-frame, then a clean frame.
        run_frame(32'h3000, 3, 2, 0, 1, 1, 0, 150);
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle("mid_reset");
        rst_n = 1'b1;
        bus.rsp_valid = 1'b0;
        mq.delete();
        exp_q.delete();
        last_due = 0;
        prev_req_stall = 0;
        prev_pix_stall = 0;
        run_frame(32'h3000, 3, 2, 0, 1, 0, 0, 0);

`ifdef SCANOUT_LINEAR_MODE_EN
        run_frame(32'h2000, 2, 2, 1, 1, 0, 0, 0);
        check("lin_addr_0_1", req_log[16], 32'h2040);
        check("lin_addr_3_2", req_log[35], 32'h208C);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
